output_interface: RTL and testbench

Per-output-port stage of the mesh router that sits directly downstream of the five input interfaces. Collects the requests that the input interfaces' routing logic raises toward one output direction, arbitrates among them, and moves the winning flit into a small output FIFO. Pulses a buffer-clear back to the winning input and drives the flit to the neighbouring router (or the PE) under a send/ready handshake.

---
 rtl/noc_pkg.sv | 36 +++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/output_interface.sv | 96 +++++++++
 tb/tb_output_interface.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: direction one-hots, port count, flit type,
// output-port state encoding and a highest-index-first one-hot picker.
package noc_pkg;

    localparam int NUM_PORTS = 5;
    localparam int FLIT_W    = 64;

    localparam logic [NUM_PORTS-1:0] DIR_L  = 5'b10000;
    localparam logic [NUM_PORTS-1:0] DIR_R  = 5'b01000;
    localparam logic [NUM_PORTS-1:0] DIR_U  = 5'b00100;
    localparam logic [NUM_PORTS-1:0] DIR_D  = 5'b00010;
    localparam logic [NUM_PORTS-1:0] DIR_PE = 5'b00001;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic {
        EMPTY  = 1'b0,
        ACTIVE = 1'b1
    } oi_state_t;

    // Highest set bit wins, which is also the fixed L > R > U > D > PE order.
    function automatic logic [NUM_PORTS-1:0] msb_onehot(input logic [NUM_PORTS-1:0] v);
        logic [NUM_PORTS-1:0] r;
        logic                 found;
        r     = '0;
        found = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Five-input arbiter for one output port. With OI_RR_ARB_EN defined it is
// round-robin (search from rr_ptr toward lower index, wrapping PE->L); otherwise fixed L-first.
module rr_arbiter
    import noc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 en,
    output logic [NUM_PORTS-1:0] grant
);

    logic [NUM_PORTS-1:0] pick;

`ifdef OI_RR_ARB_EN
    logic [NUM_PORTS-1:0] rr_ptr;
    logic [NUM_PORTS-1:0] mask;
    logic [NUM_PORTS-1:0] req_hi;

    // Bits at or below the pointer are searched first; anything above is the wrap.
    assign mask   = rr_ptr | (rr_ptr - 5'd1);
    assign req_hi = req & mask;
    assign pick   = (|req_hi) ? msb_onehot(req_hi) : msb_onehot(req);

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr <= DIR_L;
        end else if (|grant) begin
            rr_ptr <= {grant[0], grant[NUM_PORTS-1:1]};
        end
    end
`else
    logic unused_clk_rst;

    assign unused_clk_rst = clk ^ rst;
    assign pick           = msb_onehot(req);
`endif

    assign grant = en ? pick : '0;

endmodule

// File: rtl/output_interface.sv
// One output port of the mesh router: arbitrates input requests into a small
// FIFO and drives flits downstream under so/ro. OI_RR_ARB_EN selects round-robin arbitration.
module output_interface
    import noc_pkg::*;
#(
    parameter int                   DATA_WIDTH   = 64,
    parameter logic [NUM_PORTS-1:0] DIRECTION    = DIR_L,
    parameter int                   BUFFER_DEPTH = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            req_in,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] data_in,
    output logic [NUM_PORTS-1:0]            buf_clear,
    input  logic                            ro,
    output logic                            so,
    output logic [DATA_WIDTH-1:0]           datao
);

    localparam int PW    = $clog2(BUFFER_DEPTH) + 1;
    localparam int IW    = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int MEM_N = 1 << IW;

    logic [NUM_PORTS-1:0]  req_eff;
    logic [NUM_PORTS-1:0]  grant;
    logic [DATA_WIDTH-1:0] win_data;
    logic [DATA_WIDTH-1:0] mem [MEM_N];
    logic [PW-1:0]         wr_ptr, rd_ptr, count;
    logic                  full, pop, accept;
    oi_state_t             state, state_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUFFER_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign req_eff = req_in & ~DIRECTION;
    assign full    = (count == PW'(BUFFER_DEPTH));
    assign so      = (state == ACTIVE);
    assign pop     = so & ro;
    // Capture is allowed while full when the head leaves on the same edge.
    assign accept  = rst & (|req_eff) & (!full | pop);

    rr_arbiter u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req_eff),
        .en    (accept),
        .grant (grant)
    );

    assign buf_clear = grant;

    always_comb begin
        win_data = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (grant[k]) win_data = data_in[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < MEM_N; i++) mem[i] <= '0;
        end else begin
            if (accept) begin
                mem[wr_ptr[IW-1:0]] <= win_data;
                wr_ptr              <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({accept, pop})
                2'b10:   count <= count + PW'(1);
                2'b01:   count <= count - PW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= EMPTY;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (accept) state_nxt = ACTIVE;
            ACTIVE:  if (pop && !accept && count == PW'(1)) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    assign datao = mem[rd_ptr[IW-1:0]];

endmodule

// File: tb/tb_output_interface.sv
// Directed bench for output_interface: three instances (L/depth1, PE/depth2,
// U/depth1) with a per-instance scoreboard of expected flits checked on each pop.
module tb_output_interface;

    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [4:0]    req_a, req_b, req_c;
    logic [5*DW-1:0] din_a, din_b, din_c;
    logic          ro_a, ro_b, ro_c;
    logic [4:0]    bc_a, bc_b, bc_c;
    logic          so_a, so_b, so_c;
    logic [DW-1:0] dout_a, dout_b, dout_c;

    logic [DW-1:0] q_a[$], q_b[$], q_c[$];
    int n_cmp = 0;
    int n_err = 0;

    output_interface #(.DATA_WIDTH(DW), .DIRECTION(5'b10000), .BUFFER_DEPTH(1)) dut_a (
        .clk(clk), .rst(rst), .req_in(req_a), .data_in(din_a), .buf_clear(bc_a),
        .ro(ro_a), .so(so_a), .datao(dout_a));

    output_interface #(.DATA_WIDTH(DW), .DIRECTION(5'b00001), .BUFFER_DEPTH(2)) dut_b (
        .clk(clk), .rst(rst), .req_in(req_b), .data_in(din_b), .buf_clear(bc_b),
        .ro(ro_b), .so(so_b), .datao(dout_b));

    output_interface #(.DATA_WIDTH(DW), .DIRECTION(5'b00100), .BUFFER_DEPTH(1)) dut_c (
        .clk(clk), .rst(rst), .req_in(req_c), .data_in(din_c), .buf_clear(bc_c),
        .ro(ro_c), .so(so_c), .datao(dout_c));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every pop is compared against the oldest expected flit.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (so_a && ro_a) begin
                if (q_a.size() == 0) chk("a_unexpected_pop", dout_a, 64'hx);
                else                 chk("a_pop_data", dout_a, q_a.pop_front());
            end
            if (so_b && ro_b) begin
                if (q_b.size() == 0) chk("b_unexpected_pop", dout_b, 64'hx);
                else                 chk("b_pop_data", dout_b, q_b.pop_front());
            end
            if (so_c && ro_c) begin
                if (q_c.size() == 0) chk("c_unexpected_pop", dout_c, 64'hx);
                else                 chk("c_pop_data", dout_c, q_c.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] exp_g;
        rst   = 1'b0;
        req_a = '0; req_c = '0;
        req_b = 5'b11111;
        din_a = '0; din_c = '0;
        for (int k = 0; k < 5; k++) din_b[k*DW +: DW] = 64'h1000 + 64'(k);
        ro_a = 1'b0; ro_b = 1'b0; ro_c = 1'b0;

        // Reset held 3 cycles with all requests raised
        repeat (3) begin
            @(negedge clk);
            chk("rst_so", so_b, 0);
            chk("rst_datao", dout_b, 0);
            chk("rst_buf_clear", bc_b, 0);
        end
        tick();
        rst = 1'b1; ro_b = 1'b1;
        @(negedge clk);
        chk("first_grant_L", bc_b, 5'b10000);
        q_b.push_back(64'h1004);
        tick();
        req_b = '0;
        @(negedge clk);
        chk("first_so", so_b, 1);
        chk("first_bc_idle", bc_b, 0);
        tick();
        @(negedge clk);
        chk("first_so_drop", so_b, 0);

        // Single flit from PE into the L port
        tick();
        req_a = 5'b00001; din_a[0 +: DW] = 64'hA5A5; ro_a = 1'b1;
        @(negedge clk);
        chk("single_bc", bc_a, 5'b00001);
        q_a.push_back(64'hA5A5);
        tick();
        req_a = '0;
        @(negedge clk);
        chk("single_so", so_a, 1);
        chk("single_datao", dout_a, 64'hA5A5);
        chk("single_bc_off", bc_a, 0);
        tick();
        @(negedge clk);
        chk("single_so_drop", so_a, 0);

        // Backpressure on the depth-2 port
        tick();
        ro_b = 1'b0; req_b = 5'b00010; din_b[1*DW +: DW] = 64'hB1;
        @(negedge clk);
        chk("bp_grant1", bc_b, 5'b00010);
        q_b.push_back(64'hB1);
        tick();
        din_b[1*DW +: DW] = 64'hB2;
        @(negedge clk);
        chk("bp_grant2", bc_b, 5'b00010);
        q_b.push_back(64'hB2);
        tick();
        din_b[1*DW +: DW] = 64'hB3;
        q_b.push_back(64'hB3);
        @(negedge clk);
        chk("bp_full_no_grant", bc_b, 0);
        chk("bp_head_valid", so_b, 1);
        chk("bp_head_data", dout_b, 64'hB1);
        tick();
        @(negedge clk);
        chk("bp_full_hold", bc_b, 0);
        chk("bp_head_stable", dout_b, 64'hB1);
        tick();
        ro_b = 1'b1;
        @(negedge clk);
        chk("bp_grant_on_pop", bc_b, 5'b00010);
        tick();
        req_b = '0;
        @(negedge clk);
        chk("bp_drain_bc", bc_b, 0);
        tick();
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("bp_drained", so_b, 0);

        // Arbitration with L,R,U,D held toward the PE port
        for (int k = 0; k < 5; k++) din_b[k*DW +: DW] = 64'h1000 + 64'(k);
        tick();
        req_b = 5'b11110;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
`ifdef OI_RR_ARB_EN
            exp_g = 5'b10000 >> (i % 4);
`else
            exp_g = 5'b10000;
`endif
            chk("arb_grant", bc_b, exp_g);
            for (int k = 0; k < 5; k++) if (exp_g[k]) q_b.push_back(64'h1000 + 64'(k));
            tick();
        end
        req_b = '0;
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("arb_drained", so_b, 0);

        // U-turn mask on the U port
        tick();
        req_c = 5'b00100; din_c[2*DW +: DW] = 64'hC0C0; din_c[1*DW +: DW] = 64'hD0D0; ro_c = 1'b1;
        @(negedge clk);
        chk("uturn_bc", bc_c, 0);
        chk("uturn_so", so_c, 0);
        tick();
        @(negedge clk);
        chk("uturn_so_hold", so_c, 0);
        tick();
        req_c = 5'b00110;
        @(negedge clk);
        chk("uturn_grant_D", bc_c, 5'b00010);
        q_c.push_back(64'hD0D0);
        tick();
        req_c = '0;
        @(negedge clk);
        chk("uturn_so_D", so_c, 1);
        chk("uturn_datao_D", dout_c, 64'hD0D0);

        // Fill the depth-2 port, then pulse reset
        tick();
        ro_b = 1'b0; req_b = 5'b00010; din_b[1*DW +: DW] = 64'hE1;
        @(negedge clk);
        chk("mid_fill1", bc_b, 5'b00010);
        tick();
        din_b[1*DW +: DW] = 64'hE2;
        @(negedge clk);
        chk("mid_fill2", bc_b, 5'b00010);
        tick();
        req_b = '0;
        @(negedge clk);
        chk("mid_full_so", so_b, 1);
        chk("mid_full_head", dout_b, 64'hE1);
        tick();
        rst = 1'b0;
        req_b = 5'b01010;
        @(negedge clk);
        chk("mid_rst_bc_forced", bc_b, 0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_so", so_b, 0);
        chk("mid_rst_datao", dout_b, 0);
        // Pointer must be back at L: R wins over D
        chk("mid_rst_grant", bc_b, 5'b01000);
        q_b.push_back(64'h1003);
        tick();
        req_b = '0; ro_b = 1'b1;
        @(negedge clk);
        chk("mid_rst_so_after", so_b, 1);
        tick();
        @(negedge clk);
        chk("mid_rst_drained", so_b, 0);

        tick();
        tick();
        chk("q_a_empty", 64'(q_a.size()), 0);
        chk("q_b_empty", 64'(q_b.size()), 0);
        chk("q_c_empty", 64'(q_c.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
